delay_sum_beamformer: RTL

Delay-and-sum beamforming stage directly downstream of the 4-channel ADC sampler. On each completed sample frame, marked by a rising edge of `new_sample`, it performs three steps. It stores the four 8-bit channel samples in per-channel circular history buffers. It selects, per channel, the sample from a programmable number of frames ago. It outputs the signed sum as one steered beam sample with a single-cycle valid strobe.

---
 rtl/delay_sum_beamformer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: captures 4-channel ADC frames into circular histories and
// emits the signed sum of per-channel delayed samples as one steered beam sample.
module delay_sum_beamformer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8,
    parameter int unsigned DLY_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_sample,
    input  logic [DW-1:0]    ch0,
    input  logic [DW-1:0]    ch1,
    input  logic [DW-1:0]    ch2,
    input  logic [DW-1:0]    ch3,
    input  logic [DLY_W-1:0] dly0,
    input  logic [DLY_W-1:0] dly1,
    input  logic [DLY_W-1:0] dly2,
    input  logic [DLY_W-1:0] dly3,
    output logic [DW+1:0]    beam_out,
    output logic             beam_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = DW + 2;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StAcc0,
        StAcc1,
        StAcc2,
        StAcc3,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic                    ns_q;
    logic                    frame_edge;
    logic                    do_capture;
    logic                    do_write;
    logic                    do_acc;
    logic                    do_done;
    logic [1:0]              acc_sel;

    logic [DW-1:0]           ch_raw  [NCH];
    logic [DLY_W-1:0]        dly_raw [NCH];
    logic signed [DW-1:0]    cap_q   [NCH];
    logic [DLY_W-1:0]        dly_q   [NCH];
    logic signed [DW-1:0]    hist_q  [NCH][DEPTH];

    logic [DLY_W-1:0]        wr_ptr_q;
    logic [DLY_W-1:0]        cur_q;
    logic [DLY_W-1:0]        rd_idx;
    logic signed [DW-1:0]    rd_sample;
    logic signed [AW-1:0]    rd_ext;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]           beam_q;
    logic                    beam_valid_q;
    logic                    overrun_q;

    always_comb begin
        ch_raw[0]  = ch0;
        ch_raw[1]  = ch1;
        ch_raw[2]  = ch2;
        ch_raw[3]  = ch3;
        dly_raw[0] = dly0;
        dly_raw[1] = dly1;
        dly_raw[2] = dly2;
        dly_raw[3] = dly3;
    end

    // Only the first cycle of a high new_sample level counts as a frame.
    assign frame_edge = new_sample & ~ns_q;
    assign do_capture = frame_edge & (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            ns_q <= 1'b0;
        end else begin
            ns_q <= new_sample;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_edge) state_d = StWrite;
            StWrite: state_d = StAcc0;
            StAcc0:  state_d = StAcc1;
            StAcc1:  state_d = StAcc2;
            StAcc2:  state_d = StAcc3;
            StAcc3:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: decoded controls
    always_comb begin
        busy     = (state_q != StIdle);
        do_write = 1'b0;
        do_acc   = 1'b0;
        do_done  = 1'b0;
        acc_sel  = 2'd0;
        unique case (state_q)
            StWrite: do_write = 1'b1;
            StAcc0: begin
                do_acc  = 1'b1;
                acc_sel = 2'd0;
            end
            StAcc1: begin
                do_acc  = 1'b1;
                acc_sel = 2'd1;
            end
            StAcc2: begin
                do_acc  = 1'b1;
                acc_sel = 2'd2;
            end
            StAcc3: begin
                do_acc  = 1'b1;
                acc_sel = 2'd3;
            end
            StDone:  do_done = 1'b1;
            default: ;
        endcase
    end

    // Offset-binary to two's complement is an MSB flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(NCH); c++) begin
                cap_q[c] <= '0;
                dly_q[c] <= '0;
            end
        end else if (do_capture) begin
            for (int c = 0; c < int'(NCH); c++) begin
                cap_q[c] <= {~ch_raw[c][DW-1], ch_raw[c][DW-2:0]};
                dly_q[c] <= dly_raw[c];
            end
        end
    end

    // History cleared on reset so unprimed taps contribute silence.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(NCH); c++) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    hist_q[c][i] <= '0;
                end
            end
        end else if (do_write) begin
            for (int c = 0; c < int'(NCH); c++) begin
                hist_q[c][wr_ptr_q] <= cap_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            cur_q    <= '0;
        end else if (do_write) begin
            wr_ptr_q <= wr_ptr_q + DLY_W'(1);
            cur_q    <= wr_ptr_q;
        end
    end

    // DLY_W-bit subtraction gives the modulo-DEPTH tap index for free.
    assign rd_idx    = cur_q - dly_q[acc_sel];
    assign rd_sample = hist_q[acc_sel][rd_idx];
    assign rd_ext    = $signed({{(AW - DW){rd_sample[DW-1]}}, rd_sample});

    always_comb begin
        acc_d = acc_q;
        if (do_write) begin
            acc_d = '0;
        end else if (do_acc) begin
            acc_d = acc_q + rd_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beam_q       <= '0;
            beam_valid_q <= 1'b0;
        end else begin
            beam_valid_q <= do_done;
            if (do_done) begin
                beam_q <= acc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (frame_edge && busy) begin
            overrun_q <= 1'b1;
        end
    end

    assign beam_out   = beam_q;
    assign beam_valid = beam_valid_q;
    assign overrun    = overrun_q;

endmodule
